// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle rasteriser.
// Holds the FSM state encoding, the draw-mode codes and the default screen size.
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_FILL    = 2'b00;
  localparam logic [MODE_W-1:0] MODE_OUTLINE = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ERASE   = 2'b10;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster-order dx/dy counter over a w x h rectangle, with x stepping fastest.
// It flags the final pixel and any pixel that lies on the rectangle border.
module rect_scan_counter #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] dx,
  output logic [Y_W-1:0] dy,
  output logic           last,
  output logic           on_edge
);

  logic [X_W-1:0] x_max;
  logic [Y_W-1:0] y_max;
  logic           x_end;
  logic           y_end;

  assign x_max   = w - X_W'(1);
  assign y_max   = h - Y_W'(1);
  assign x_end   = (dx == x_max);
  assign y_end   = (dy == y_max);
  assign last    = x_end && y_end;
  assign on_edge = (dx == '0) || x_end || (dy == '0) || y_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (x_end) begin
        dx <= '0;
        dy <= dy + Y_W'(1);
      end else begin
        dx <= dx + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_drawer.sv
// Rectangle rasteriser: latches geometry on start and streams one pixel per clock.
// Supports fill, outline and erase modes, screen clipping, abort and a done pulse.
module rect_drawer
  import draw_pkg::*;
#(
  parameter int unsigned          X_W       = 8,
  parameter int unsigned          Y_W       = 7,
  parameter int unsigned          COLOUR_W  = 3,
  parameter int unsigned          SCREEN_W  = DEF_SCREEN_W,
  parameter int unsigned          SCREEN_H  = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [MODE_W-1:0]   mode,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [X_W:0] LIM_X = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LIM_Y = (Y_W+1)'(SCREEN_H);

  state_t                state;
  logic [X_W-1:0]        x0_r;
  logic [Y_W-1:0]        y0_r;
  logic [X_W-1:0]        w_r;
  logic [Y_W-1:0]        h_r;
  logic [COLOUR_W-1:0]   colour_r;
  logic [MODE_W-1:0]     mode_r;

  logic [X_W-1:0]        dx;
  logic [Y_W-1:0]        dy;
  logic                  last;
  logic                  on_edge;
  logic                  accept;
  logic                  step;
  logic                  zero_size;
  logic [X_W:0]          sum_x;
  logic [Y_W:0]          sum_y;
  logic                  visible;
  logic                  mode_ok;

  assign zero_size = (w == '0) || (h == '0);
  assign accept    = (state == ST_IDLE) && start;
  assign step      = (state == ST_DRAW) && !abort;

  rect_scan_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .en      (step),
    .w       (w_r),
    .h       (h_r),
    .dx      (dx),
    .dy      (dy),
    .last    (last),
    .on_edge (on_edge)
  );

  // Control FSM plus the request latches; abort wins over stepping and completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= '0;
      h_r      <= '0;
      colour_r <= '0;
      mode_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (zero_size) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_DRAW;
              x0_r     <= x0;
              y0_r     <= y0;
              w_r      <= w;
              h_r      <= h;
              colour_r <= colour;
              mode_r   <= mode;
            end
          end
        end
        ST_DRAW: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel address at one extra bit so wrap-around is seen as off-screen.
  assign sum_x   = {1'b0, x0_r} + {1'b0, dx};
  assign sum_y   = {1'b0, y0_r} + {1'b0, dy};
  assign visible = !sum_x[X_W] && (sum_x < LIM_X) && !sum_y[Y_W] && (sum_y < LIM_Y);
  assign mode_ok = (mode_r != MODE_OUTLINE) || on_edge;

  assign out_x      = sum_x[X_W-1:0];
  assign out_y      = sum_y[Y_W-1:0];
  assign out_colour = (mode_r == MODE_ERASE) ? BG_COLOUR : colour_r;
  assign plot       = (state == ST_DRAW) && visible && mode_ok;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_rect_drawer.sv
// Self-checking bench for rect_drawer against a loop-based raster model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rect_drawer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] w = '0;
  logic [6:0] h = '0;
  logic [2:0] colour = '0;
  logic [1:0] mode = '0;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       plot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  rect_drawer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .colour     (colour),
    .mode       (mode),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Issues a request at the current falling edge and checks every following cycle
  // against a per-pixel model; abort_after>0 aborts once that many pixels were seen.
  task automatic run_draw(input logic [7:0] ax0, input logic [6:0] ay0,
                          input logic [7:0] aw, input logic [6:0] ah,
                          input logic [2:0] acol, input logic [1:0] amode,
                          input int abort_after, input bit mid_start,
                          input string name, output int plots);
    int         n;
    int         idx;
    int         sx;
    int         sy;
    bit         vis;
    bit         brd;
    logic       eplot;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    plots = 0;
    x0 = ax0; y0 = ay0; w = aw; h = ah; colour = acol; mode = amode; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
    colour = 3'($urandom); mode = 2'($urandom);
    n = int'(aw) * int'(ah);
    if (n == 0) begin
      n_checks++;
      if ({busy, done, plot} !== 3'b110) begin
        n_fail++;
        $display("FAIL %s zero_done: got busy/done/plot=%b want 110", name, {busy, done, plot});
      end
      @(negedge clock);
      n_checks++;
      if ({busy, done, plot} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s zero_idle: got busy/done/plot=%b want 000", name, {busy, done, plot});
      end
      return;
    end
    idx = 0;
    for (int r = 0; r < int'(ah); r++) begin
      for (int c = 0; c < int'(aw); c++) begin
        start = (mid_start && idx == 1);
        sx    = int'(ax0) + c;
        sy    = int'(ay0) + r;
        vis   = (sx < 160) && (sy < 120);
        brd   = (r == 0) || (c == 0) || (r == int'(ah) - 1) || (c == int'(aw) - 1);
        eplot = vis && (amode != 2'b01 || brd);
        ex    = 8'(sx);
        ey    = 7'(sy);
        ec    = (amode == 2'b10) ? 3'b000 : acol;
        if (plot === 1'b1) plots++;
        n_checks++;
        if ({busy, done, plot, out_x, out_y, out_colour} !== {2'b10, eplot, ex, ey, ec}) begin
          n_fail++;
          $display("FAIL %s pixel(%0d,%0d): got b/d/p=%b%b%b x=%0d y=%0d c=%b want p=%b x=%0d y=%0d c=%b",
                   name, c, r, busy, done, plot, out_x, out_y, out_colour, eplot, ex, ey, ec);
        end
        idx++;
        if (abort_after > 0 && idx == abort_after) begin
          abort = 1'b1;
          @(negedge clock);
          abort = 1'b0;
          start = 1'b0;
          n_checks++;
          if ({busy, done, plot} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s abort_idle: got busy/done/plot=%b want 000", name, {busy, done, plot});
          end
          return;
        end
        @(negedge clock);
      end
    end
    start = 1'b0;
    n_checks++;
    if ({busy, done, plot} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s done_cycle: got busy/done/plot=%b want 110", name, {busy, done, plot});
    end
    @(negedge clock);
    n_checks++;
    if ({busy, done, plot} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s after_done: got busy/done/plot=%b want 000", name, {busy, done, plot});
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({out_x, out_y, out_colour, plot, busy, done} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_values: got x=%0d y=%0d c=%b p=%b b=%b d=%b want all 0",
               out_x, out_y, out_colour, plot, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got p/b/d=%b want 000", {plot, busy, done});
    end
  endtask

  task automatic test_fill();
    int p;
    run_draw(8'd10, 7'd20, 8'd3, 7'd2, 3'b101, 2'b00, 0, 1'b0, "fill3x2", p);
    n_checks++;
    if (p !== 6) begin
      n_fail++;
      $display("FAIL fill3x2_count: got %0d plots want 6", p);
    end
  endtask

  task automatic test_outline();
    int p;
    run_draw(8'd0, 7'd0, 8'd4, 7'd3, 3'b011, 2'b01, 0, 1'b0, "outline4x3", p);
    n_checks++;
    if (p !== 10) begin
      n_fail++;
      $display("FAIL outline4x3_count: got %0d plots want 10", p);
    end
  endtask

  task automatic test_clip();
    int p;
    run_draw(8'd158, 7'd119, 8'd4, 7'd1, 3'b110, 2'b00, 0, 1'b0, "clip_edge", p);
    n_checks++;
    if (p !== 2) begin
      n_fail++;
      $display("FAIL clip_edge_count: got %0d plots want 2", p);
    end
    run_draw(8'd254, 7'd3, 8'd4, 7'd1, 3'b001, 2'b00, 0, 1'b0, "clip_wrap", p);
    n_checks++;
    if (p !== 0) begin
      n_fail++;
      $display("FAIL clip_wrap_count: got %0d plots want 0", p);
    end
    run_draw(8'd2, 7'd126, 8'd2, 7'd3, 3'b010, 2'b11, 0, 1'b0, "clip_ywrap", p);
  endtask

  task automatic test_zero();
    int p;
    run_draw(8'd5, 7'd5, 8'd0, 7'd5, 3'b111, 2'b00, 0, 1'b0, "zero_w", p);
    run_draw(8'd5, 7'd5, 8'd7, 7'd0, 3'b111, 2'b01, 0, 1'b0, "zero_h", p);
  endtask

  task automatic test_abort();
    int p;
    run_draw(8'd0, 7'd0, 8'd8, 7'd8, 3'b100, 2'b00, 10, 1'b0, "abort8x8", p);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_quiet%0d: got busy/done=%b want 00", i, {busy, done});
      end
    end
    run_draw(8'd30, 7'd40, 8'd2, 7'd2, 3'b010, 2'b00, 0, 1'b0, "after_abort", p);
    // Abort while idle must be ignored by the next request
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    run_draw(8'd1, 7'd1, 8'd2, 7'd1, 3'b001, 2'b00, 0, 1'b0, "idle_abort", p);
  endtask

  task automatic test_reset_mid();
    x0 = 8'd5; y0 = 7'd5; w = 8'd8; h = 7'd8; colour = 3'b111; mode = 2'b00; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_x, out_y, out_colour, plot, busy, done} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got x=%0d y=%0d c=%b p=%b b=%b d=%b want all 0",
               out_x, out_y, out_colour, plot, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, done, plot} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got busy/done/plot=%b want 000", {busy, done, plot});
    end
  endtask

  task automatic test_erase();
    int p;
    run_draw(8'd50, 7'd60, 8'd2, 7'd2, 3'b111, 2'b10, 0, 1'b1, "erase2x2", p);
    n_checks++;
    if (p !== 4) begin
      n_fail++;
      $display("FAIL erase2x2_count: got %0d plots want 4", p);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    run_draw(8'd100, 7'd100, 8'd3, 7'd3, 3'b011, 2'b01, 0, 1'b0, "b2b_a", p);
    run_draw(8'd101, 7'd101, 8'd1, 7'd1, 3'b101, 2'b00, 0, 1'b0, "b2b_b", p);
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 30; i++) begin
      run_draw(8'($urandom), 7'($urandom), 8'($urandom_range(0, 12)), 7'($urandom_range(0, 6)),
               3'($urandom), 2'($urandom), 0, ($urandom_range(0, 1) == 1), "random", p);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_zero();
    test_abort();
    test_reset_mid();
    test_erase();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
